// File: rtl/sd_block_server.sv
// sd_block_server: serves sd_lba/sd_rd/sd_wr 512-byte block requests from a toggle req/ack word store.
module sd_block_server #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter int          ACK_DELAY = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [7:0]  sd_buff_addr,
  output logic [15:0] sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [15:0] sd_buff_din,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_dout,
  output logic        mem_we_req,
  input  logic        mem_we_ack,
  output logic        mem_rd_req,
  input  logic        mem_rd_ack,
  input  logic [15:0] mem_din,
  output logic        busy
);
  typedef enum logic [3:0] {IDLE, DELAY, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_CAP, WR_REQ, WR_WAIT, DONE} state_t;
  localparam logic [3:0] ACK_D = 4'(ACK_DELAY);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] idx, idx_n, baddr_n;
  logic [15:0] lba, lba_n, bdout_n, mdout_n;
  logic [23:0] maddr_n, word_addr;
  logic dir_rd, rd_n, ack_n, bwr_n, we_n, rdq_n, busy_n, last;
  logic unused_lba;
  assign unused_lba = ^sd_lba[31:16];
  assign word_addr = BASE_ADDR + {lba, idx};
  assign last = idx == 8'hFF;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    lba_n = lba;
    rd_n = dir_rd;
    ack_n = sd_ack;
    baddr_n = sd_buff_addr;
    bdout_n = sd_buff_dout;
    bwr_n = 1'b0;
    maddr_n = mem_addr;
    mdout_n = mem_dout;
    we_n = mem_we_req;
    rdq_n = mem_rd_req;
    busy_n = busy;
    case (state)
      IDLE: if (sd_rd || sd_wr) begin
        state_n = DELAY;
        lba_n = sd_lba[15:0];
        rd_n = sd_rd;
        idx_n = '0;
        cnt_n = '0;
        busy_n = 1'b1;
      end
      DELAY: if (cnt == ACK_D) begin
        ack_n = 1'b1;
        baddr_n = '0;
        state_n = dir_rd ? RD_REQ : WR_ADDR;
      end else cnt_n = cnt + 4'd1;
      RD_REQ: begin
        maddr_n = word_addr;
        rdq_n = ~mem_rd_req;
        state_n = RD_WAIT;
      end
      RD_WAIT: if (mem_rd_ack == mem_rd_req) begin
        bdout_n = mem_din;
        baddr_n = idx;
        bwr_n = 1'b1;
        state_n = RD_PUT;
      end
      RD_PUT: begin
        idx_n = last ? idx : idx + 8'd1;
        ack_n = !last;
        state_n = last ? DONE : RD_REQ;
      end
      // sd_buff_addr changed on entry; the client's registered data is ready two edges later
      WR_ADDR: state_n = WR_CAP;
      WR_CAP: begin
        mdout_n = sd_buff_din;
        maddr_n = word_addr;
        state_n = WR_REQ;
      end
      WR_REQ: begin
        we_n = ~mem_we_req;
        state_n = WR_WAIT;
      end
      WR_WAIT: if (mem_we_ack == mem_we_req) begin
        idx_n = last ? idx : idx + 8'd1;
        baddr_n = last ? sd_buff_addr : idx + 8'd1;
        ack_n = !last;
        state_n = last ? DONE : WR_ADDR;
      end
      DONE: begin
        busy_n = 1'b0;
        idx_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      lba <= '0;
      dir_rd <= 1'b0;
      sd_ack <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
      mem_we_req <= 1'b0;
      mem_rd_req <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      lba <= lba_n;
      dir_rd <= rd_n;
      sd_ack <= ack_n;
      sd_buff_addr <= baddr_n;
      sd_buff_dout <= bdout_n;
      sd_buff_wr <= bwr_n;
      mem_addr <= maddr_n;
      mem_dout <= mdout_n;
      mem_we_req <= we_n;
      mem_rd_req <= rdq_n;
      busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_sd_block_server.sv
// tb_sd_block_server: randomized block transfers against a toggle-protocol store and a scoreboard.
module tb_sd_block_server;
  localparam int BASE = 32'hFFFF80;
  localparam int ACK = 4;
  typedef struct {logic we; logic [23:0] a; logic [15:0] d;} acc_t;
  typedef struct {logic [7:0] a; logic [15:0] d;} rd_t;
  logic clk_sys = 0, reset = 1, sd_rd = 0, sd_wr = 0;
  logic [31:0] sd_lba = '0;
  logic sd_ack, sd_buff_wr, mem_we_req, mem_rd_req, busy;
  logic mem_we_ack = 0, mem_rd_ack = 0;
  logic [7:0] sd_buff_addr;
  logic [15:0] sd_buff_dout, mem_dout, sd_buff_din = '0, mem_din = '0;
  logic [23:0] mem_addr;
  logic [15:0] cbram [256];
  logic [15:0] store [int];
  logic [15:0] ref_mem [int];
  acc_t exp_acc[$];
  rd_t exp_rd[$];
  int errors = 0, checks = 0, lat_max = 1, wr_total = 0, strobes = 0;
  int rd_wait = -1, we_wait = -1;
  sd_block_server #(.BASE_ADDR(24'hFFFF80), .ACK_DELAY(ACK)) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_we_req(mem_we_req), .mem_we_ack(mem_we_ack),
    .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_din(mem_din), .busy(busy)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int waddr(input int lba, input int i);
    return (BASE + lba * 256 + i) & 32'hFFFFFF;
  endfunction
  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : a[15:0];
  endfunction
  // client block buffer with one cycle of read latency
  always @(posedge clk_sys) sd_buff_din <= cbram[sd_buff_addr];
  // backing store: answers each toggle after a random latency of 1..lat_max cycles
  always @(posedge clk_sys) begin
    if (reset) begin
      mem_rd_ack <= 1'b0;
      mem_we_ack <= 1'b0;
      rd_wait = -1;
      we_wait = -1;
    end else begin
      if (mem_rd_req != mem_rd_ack) begin
        if (rd_wait < 0) rd_wait = $urandom_range(lat_max, 1) - 1;
        if (rd_wait == 0) begin
          mem_din <= store.exists(int'(mem_addr)) ? store[int'(mem_addr)] : mem_addr[15:0];
          mem_rd_ack <= mem_rd_req;
        end
        rd_wait--;
      end
      if (mem_we_req != mem_we_ack) begin
        if (we_wait < 0) we_wait = $urandom_range(lat_max, 1) - 1;
        if (we_wait == 0) begin
          store[int'(mem_addr)] = mem_dout;
          wr_total++;
          mem_we_ack <= mem_we_req;
        end
        we_wait--;
      end
    end
  end
  // monitor: store accesses and client strobes against the expected queues
  logic last_rd = 0, last_we = 0, prev_wr = 0;
  always @(negedge clk_sys) begin
    acc_t e;
    rd_t r;
    if (reset) begin
      last_rd = 0;
      last_we = 0;
      prev_wr = 0;
    end else begin
      if (sd_buff_wr) begin
        strobes++;
        check("strobe_gap", 32'(prev_wr), 0);
        if (exp_rd.size() == 0) check("spurious_strobe", 1, 0);
        else begin
          r = exp_rd.pop_front();
          check("strobe_addr_data", 32'({sd_buff_addr, sd_buff_dout}), 32'({r.a, r.d}));
        end
      end
      prev_wr = sd_buff_wr;
      if (mem_rd_req != last_rd || mem_we_req != last_we) begin
        if (exp_acc.size() == 0) check("spurious_access", 1, 0);
        else begin
          e = exp_acc.pop_front();
          check("acc_kind", 32'(mem_we_req != last_we), 32'(e.we));
          check("acc_addr", 32'(mem_addr), 32'(e.a));
          if (e.we) check("acc_data", 32'(mem_dout), 32'(e.d));
        end
      end
      last_rd = mem_rd_req;
      last_we = mem_we_req;
    end
  end
  task automatic queue_read(input int lba);
    for (int i = 0; i < 256; i++) begin
      exp_acc.push_back('{1'b0, 24'(waddr(lba, i)), 16'h0});
      exp_rd.push_back('{8'(i), ref_rd(waddr(lba, i))});
    end
  endtask
  task automatic queue_write(input int lba);
    for (int i = 0; i < 256; i++) begin
      exp_acc.push_back('{1'b1, 24'(waddr(lba, i)), cbram[i]});
      ref_mem[waddr(lba, i)] = cbram[i];
    end
  endtask
  task automatic xfer(input logic rd, input logic wr, input int lba);
    int n;
    logic prev, acc;
    if (rd) queue_read(lba);
    else queue_write(lba);
    sd_lba = {16'($urandom), 16'(lba)};
    sd_rd = rd;
    sd_wr = wr;
    prev = busy;
    n = 0;
    acc = 0;
    while (!acc && n < 20) begin
      @(posedge clk_sys); #1;
      n++;
      acc = !prev && busy;
      prev = busy;
    end
    check("accept", 32'(acc), 1);
    n = 0;
    while (!sd_ack && n < 50) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("ack_delay", n, ACK + 1);
    sd_rd = 0;
    sd_wr = 0;
    n = 0;
    while (sd_ack && n < 20000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("ack_fall", 32'(sd_ack), 0);
    check("drain_strobes", exp_rd.size(), 0);
    check("drain_access", exp_acc.size(), 0);
  endtask
  initial begin
    int w0, target, n;
    for (int i = 0; i < 256; i++) cbram[i] = 16'($urandom);
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_ctl", 32'({sd_ack, sd_buff_wr, mem_we_req, mem_rd_req, busy}), 0);
    check("rst_buf", 32'({sd_buff_addr, sd_buff_dout}), 0);
    check("rst_mem", 32'({mem_addr, 8'h0}) | 32'(mem_dout), 0);
    reset = 0;
    xfer(1, 0, 5);
    for (int i = 0; i < 256; i++) cbram[i] = ~16'(i);
    w0 = wr_total;
    xfer(0, 1, 3);
    check("write_count", wr_total - w0, 256);
    lat_max = 20;
    w0 = wr_total;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 256; i++) cbram[i] = 16'($urandom);
      xfer(0, 1, 'h100 + b);
    end
    check("save_count", wr_total - w0, 8 * 256);
    lat_max = 3;
    for (int b = 0; b < 8; b++) xfer(1, 0, 'h100 + b);
    lat_max = 1;
    w0 = wr_total;
    xfer(1, 1, 3);
    check("simul_no_writes", wr_total - w0, 0);
    queue_read('h101);
    target = strobes + 100;
    sd_lba = 32'h101;
    sd_rd = 1;
    n = 0;
    while (strobes < target && n < 5000) begin
      @(posedge clk_sys); #1;
      n++;
      if (sd_ack) sd_rd = 0;
    end
    check("reached_word100", 32'(strobes >= target), 1);
    sd_rd = 0;
    reset = 1;
    @(posedge clk_sys); #1;
    check("midreset_state", 32'({sd_ack, busy, mem_we_req, mem_rd_req}), 0);
    @(posedge clk_sys); #1;
    reset = 0;
    exp_rd.delete();
    exp_acc.delete();
    xfer(1, 0, 'h101);
    xfer(1, 0, 0);
    xfer(0, 1, 0);
    xfer(1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
